seq_detect_prog: RTL

//  Programmable serial bit-sequence detector: parametrised successor to the fixed 3-bit "001" FSM.

---
 rtl/seq_detect_pkg.sv | 20 ++
 rtl/seq_detect_prog_if.sv | 30 +++
 rtl/seq_hist_shreg.sv | 40 ++++
 rtl/seq_detect_prog.sv | 119 +++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and reset defaults for the programmable sequence detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    FILLING = 2'd0,
    ARMED   = 2'd1,
    HIT     = 2'd2
  } seq_state_t;

  // Reset configuration: behaves as the legacy fixed "001" detector.
  localparam int DEF_PATTERN = 'b001;
  localparam int DEF_LEN     = 3;
  localparam bit DEF_OVERLAP = 1'b1;

  // Width needed to hold a length value in the range 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// Serial stream, configuration and result signals of seq_detect_prog.
interface seq_detect_prog_if
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
);
  localparam int LEN_W = len_w(MAX_LEN);

  logic               din;
  logic               din_valid;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               detect;
  logic [LEN_W-1:0]   hist_fill;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output din, din_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap,
    input  detect, hist_fill, match_cnt
  );

  modport slave (
    input  din, din_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap,
    output detect, hist_fill, match_cnt
  );

endinterface

// File: rtl/seq_hist_shreg.sv
// History shifter plus saturating fill counter. Next-state values are exported
// so the top can compare against the history as it will look after this sample.
module seq_hist_shreg
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               din,
  input  logic [LEN_W-1:0]   len,
  output logic [MAX_LEN-1:0] hist_nxt,
  output logic [LEN_W-1:0]   fill,
  output logic [LEN_W-1:0]   fill_nxt
);

  logic [MAX_LEN-1:0] hist;

  // Newest bit enters at bit 0; fill never exceeds the active length.
  always_comb begin
    hist_nxt = {hist[MAX_LEN-2:0], din};
    fill_nxt = (fill >= len) ? len : fill + LEN_W'(1);
  end

  // History always shifts on a sample; clr only discards the fill count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else begin
      if (en) hist <= hist_nxt;
      if (clr)     fill <= '0;
      else if (en) fill <= fill_nxt;
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-sequence detector.
// Optional feature: define MATCH_CNT_EN to build the saturating match counter;
// without it match_cnt is tied to zero and no counter flops exist.
//
// state   | meaning
// FILLING | fewer than len valid history bits
// ARMED   | history full, next sample can match
// HIT     | detect cycle (detect is decoded from this state)
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_detect_prog_if.slave     bus
);

  localparam int LEN_W = len_w(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [LEN_W-1:0]   len_clamp;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_nxt;
  logic [LEN_W-1:0]   fill_after;
  logic               sample;
  logic               match;
  logic               clr;
  seq_state_t         state_q;
  seq_state_t         state_n;

  // Clamp requested length into 1..MAX_LEN before storing.
  always_comb begin
    len_clamp = bus.cfg_len;
    if (bus.cfg_len == '0)                      len_clamp = LEN_W'(1);
    else if (bus.cfg_len > LEN_W'(MAX_LEN))     len_clamp = LEN_W'(MAX_LEN);
  end

  // Configuration registers, defaulting to the legacy "001" detector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pattern_q <= MAX_LEN'(DEF_PATTERN);
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
    end else if (bus.cfg_we) begin
      pattern_q <= bus.cfg_pattern;
      len_q     <= len_clamp;
      overlap_q <= bus.cfg_overlap;
    end
  end

  // A config write swallows any sample presented in the same cycle.
  assign sample = bus.din_valid & ~bus.cfg_we;

  seq_hist_shreg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (sample),
    .clr      (clr),
    .din      (bus.din),
    .len      (len_q),
    .hist_nxt (hist_nxt),
    .fill     (fill),
    .fill_nxt (fill_nxt)
  );

  // Compare only the low len bits of the post-shift history.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LEN_W'(i) < len_q);
    match = sample && (fill_nxt == len_q) && (((hist_nxt ^ pattern_q) & mask) == '0);
    clr   = bus.cfg_we | (match & ~overlap_q);
  end

  // Next state follows the fill count the shifter will hold after this edge.
  always_comb begin
    state_n    = state_q;
    fill_after = fill;
    if (clr)         fill_after = '0;
    else if (sample) fill_after = fill_nxt;
    if (bus.cfg_we)                state_n = FILLING;
    else if (match)                state_n = HIT;
    else if (fill_after == len_q)  state_n = ARMED;
    else                           state_n = FILLING;
  end

  // State register; reset discards any match in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FILLING;
    else        state_q <= state_n;
  end

  assign bus.detect    = (state_q == HIT);
  assign bus.hist_fill = fill;

`ifdef MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts alongside the detect flop so match_cnt already includes a visible pulse.
  always_ff @(posedge clk) begin
    if (!rst_n)                       cnt_q <= '0;
    else if (bus.cfg_we)              cnt_q <= '0;
    else if (match && (cnt_q != '1))  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule
